parity_chk_odd_rx: RTL and testbench
====================================

# parity_chk_odd_rx

Serial odd-parity checker and deserialiser: the receive-side counterpart of the odd-parity generator. It accepts a frame of DATA_W data bits (LSB first) followed by one odd-parity bit on a single-bit valid-qualified stream. It outputs the assembled word with a one-cycle valid strobe and a parity-error flag, and keeps a saturating count of bad frames. It sits between a serial link front end and the word-level consumer.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, 1..32.
- CNT_W, 8: width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- bit_in  input  1  serial bit; sampled only when bit_valid=1.
- bit_valid  input  1  qualifies bit_in for the current clock edge.
- abort  input  1  synchronous frame discard.
- data_out  output  DATA_W  last completed frame's data word.
- data_valid  output  1  one-cycle strobe marking a completed frame.
- par_err  output  1  parity result of the last completed frame; 1 = error.
- busy  output  1  a frame is partially received.
- err_count  output  CNT_W  saturating count of frames with par_err=1.

## Operation
- The FSM has three states:
  - IDLE: the first sampled bit is data bit 0. It loads into the shift register and the bit counter becomes 1; go to DATA (or PAR if DATA_W=1).
  - DATA: each sampled bit is stored at position bit_cnt (LSB first). When bit_cnt reaches DATA_W, go to PAR.
  - PAR: the sampled bit is the parity bit. Complete the frame and go to IDLE.
- The running parity accumulator XORs every sampled data bit. At completion, check = acc XOR parity_bit. Odd parity holds when the total number of ones across data and parity is odd: check=1 means OK (par_err=0), check=0 means error (par_err=1).
- On completion:
  - data_out takes the shift register value, with the final data bit already included.
  - par_err is updated.
  - data_valid pulses.
  - err_count increments if par_err=1, saturating at 2^CNT_W-1.
- data_out and par_err hold their values until the next completion. They are not cleared by abort.
- Gaps: cycles with bit_valid=0 leave all state unchanged, in any state, for any duration.
- abort=1 returns the FSM to IDLE, clears the bit counter and accumulator, and suppresses data_valid. abort wins over a simultaneous bit_valid; that bit is dropped. abort in IDLE has no effect.
- Reset (rst_n=0 at any time, including mid-frame) drives all outputs to reset values immediately:
  - FSM to IDLE, bit_cnt=0, accumulator=0.
  - data_out=0, data_valid=0, par_err=0, busy=0, err_count=0.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- When the parity bit is sampled at edge N, data_out, par_err and err_count update at edge N. data_valid is high from edge N to edge N+1 only.
- Back-to-back frames are allowed: a bit_valid in the data_valid cycle is data bit 0 of the next frame. The minimum frame period is DATA_W+1 cycles.
- busy rises at the edge that samples data bit 0 and falls at the edge that samples the parity bit, or at abort or reset.
- Counter width is ceil(log2(DATA_W+1)) bits. It never wraps, because the transition to PAR happens at bit_cnt=DATA_W.

## Structure
- Shared package parity_pkg holds:
  - the state enum {IDLE, DATA, PAR};
  - the default DATA_W and CNT_W constants;
  - a function odd_ok(acc, pbit) returning acc ^ pbit.
- One sub-module, parity_acc_odd: a 1-bit running XOR accumulator with clear and enable inputs. It is reusable by the generator side.
- The top level contains the FSM, shift register, bit counter and saturating error counter.

## Test plan
- 0xA5 (4 ones) + parity 1, contiguous bits -> data_valid one cycle, data_out=0xA5, par_err=0, err_count=0.
- 0xA5 + parity 0 -> data_out=0xA5, par_err=1, err_count=1. Then 0xFF + parity 1 -> par_err=0, err_count stays 1.
- 0x3C + parity 1 with 0–3 random idle cycles between bits -> same result as the contiguous case; busy stays high across the gaps.
- Abort after 5 bits, then a full 0x00 + parity 1 frame -> no strobe for the aborted frame. The next frame gives data_out=0x00 and par_err=0. abort coincident with bit_valid drops that bit.
- rst_n low for one cycle mid-frame (after 4 bits) -> all outputs 0 immediately. The next full 0x81 + parity 1 frame decodes correctly.
- 2^CNT_W+5 back-to-back bad frames -> err_count saturates at 255 (CNT_W=8). data_valid strobes exactly once per frame, every DATA_W+1 cycles.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the odd-parity serial checker and its generator counterpart.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 8;

    // Odd parity is satisfied when the XOR over data and parity bit is 1.
    function automatic logic odd_ok(input logic acc, input logic pbit);
        return acc ^ pbit;
    endfunction

endpackage

// File: rtl/parity_chk_odd_rx_if.sv
// Bus bundle between the serial front end (master) and the checker (slave).
interface parity_chk_odd_rx_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              bit_in;
    logic              bit_valid;
    logic              abort;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              par_err;
    logic              busy;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output bit_in, bit_valid, abort,
        input  data_out, data_valid, par_err, busy, err_count
    );

    modport slave (
        input  bit_in, bit_valid, abort,
        output data_out, data_valid, par_err, busy, err_count
    );
endinterface

// File: rtl/parity_acc_odd.sv
// One-bit running XOR accumulator; clear has priority over enable.
module parity_acc_odd (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic acc
);
    logic acc_r;

    // Fold each enabled bit into the running parity; clear restarts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= 1'b0;
        end else if (clr) begin
            acc_r <= 1'b0;
        end else if (en) begin
            acc_r <= acc_r ^ din;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;
endmodule

// File: rtl/parity_chk_odd_rx.sv
// Serial odd-parity checker / deserialiser: LSB-first data bits followed by an
// odd-parity bit, producing a word strobe, parity-error flag and saturating
// bad-frame counter.
module parity_chk_odd_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    parity_chk_odd_rx_if.slave bus
);
    localparam int               BC_W    = $clog2(DATA_W + 1);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    logic [BC_W-1:0]   bit_cnt_r;
    logic [BC_W-1:0]   bit_cnt_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_s;
    logic              busy_r;
    logic              busy_s;
    logic              acc_clr_s;
    logic              acc_en_s;
    logic              acc_s;
    logic              done_s;
    logic              check_ok_s;

    logic [DATA_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              par_err_r;
    logic [CNT_W-1:0]  err_cnt_r;

    parity_acc_odd u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr_s),
        .en    (acc_en_s),
        .din   (bus.bit_in),
        .acc   (acc_s)
    );

    // Only meaningful while the parity bit is being sampled.
    assign check_ok_s = odd_ok(acc_s, bus.bit_in);

    // Next-state, shift register, counter and accumulator control.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        busy_s    = busy_r;
        acc_clr_s = 1'b0;
        acc_en_s  = 1'b0;
        done_s    = 1'b0;

        if (bus.abort) begin
            // Any bit arriving with abort is dropped, even in IDLE.
            state_s   = IDLE;
            bit_cnt_s = {BC_W{1'b0}};
            acc_clr_s = 1'b1;
            busy_s    = 1'b0;
        end else if (bus.bit_valid) begin
            case (state_r)
                IDLE: begin
                    shift_s    = {DATA_W{1'b0}};
                    shift_s[0] = bus.bit_in;
                    bit_cnt_s  = BC_W'(1);
                    acc_en_s   = 1'b1;
                    busy_s     = 1'b1;
                    state_s    = (DATA_W == 1) ? PAR : DATA;
                end
                DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_r == BC_W'(i)) begin
                            shift_s[i] = bus.bit_in;
                        end else begin
                            shift_s[i] = shift_r[i];
                        end
                    end
                    bit_cnt_s = bit_cnt_r + BC_W'(1);
                    acc_en_s  = 1'b1;
                    if (bit_cnt_s == BC_LAST) begin
                        state_s = PAR;
                    end else begin
                        state_s = DATA;
                    end
                end
                PAR: begin
                    done_s    = 1'b1;
                    bit_cnt_s = {BC_W{1'b0}};
                    acc_clr_s = 1'b1;
                    busy_s    = 1'b0;
                    state_s   = IDLE;
                end
                default: begin
                    state_s   = IDLE;
                    bit_cnt_s = {BC_W{1'b0}};
                    acc_clr_s = 1'b1;
                    busy_s    = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame-tracking state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= {BC_W{1'b0}};
            shift_r   <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            busy_r    <= busy_s;
        end
    end

    // Completed-frame outputs and saturating bad-frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r   <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            par_err_r    <= 1'b0;
            err_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            data_valid_r <= done_s;
            if (done_s) begin
                data_out_r <= shift_r;
                par_err_r  <= ~check_ok_s;
                if (!check_ok_s && (err_cnt_r != CNT_MAX)) begin
                    err_cnt_r <= err_cnt_r + CNT_W'(1);
                end else begin
                    err_cnt_r <= err_cnt_r;
                end
            end else begin
                data_out_r <= data_out_r;
                par_err_r  <= par_err_r;
                err_cnt_r  <= err_cnt_r;
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.par_err    = par_err_r;
    assign bus.busy       = busy_r;
    assign bus.err_count  = err_cnt_r;

endmodule

// File: tb/tb_parity_chk_odd_rx.sv
// Directed bench for parity_chk_odd_rx with a scoreboard of expected frames.
module tb_parity_chk_odd_rx;
    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    parity_chk_odd_rx_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    parity_chk_odd_rx #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks      = 0;
    int   errors      = 0;
    int   cycle       = 0;
    int   last_strobe = -1;
    int   n_push      = 0;
    int   n_strobe    = 0;
    int   model_cnt   = 0;
    bit   b2b         = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later, score any strobe.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (bus.data_valid === 1'b1) begin
            n_strobe++;
            chk("sb_depth_at_strobe", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("data_out", 32'(bus.data_out), 32'(e.d));
                chk("par_err", 32'(bus.par_err), 32'(e.pe));
                chk("err_count", 32'(bus.err_count), 32'(e.cnt));
            end
            if (b2b && last_strobe >= 0) begin
                chk("strobe_period", cycle - last_strobe, DW + 1);
            end
            last_strobe = cycle;
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic p);
        exp_t e;
        e.d  = d;
        e.pe = ~(^{d, p});
        if (e.pe && model_cnt < 255) model_cnt++;
        e.cnt = CW'(model_cnt);
        sb.push_back(e);
        n_push++;
    endtask

    task automatic gap(input int maxgap, input bit mid);
        int n;
        n = int'($urandom_range(maxgap, 0));
        for (int g = 0; g < n; g++) begin
            bus.bit_valid = 1'b0;
            tick();
            if (mid) chk("busy_in_gap", 32'(bus.busy), 1);
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] d, input int nbits, input int maxgap);
        for (int i = 0; i < nbits; i++) begin
            gap(maxgap, i > 0);
            bus.bit_valid = 1'b1;
            bus.bit_in    = d[i];
            tick();
            chk("busy_data", 32'(bus.busy), 1);
        end
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input int maxgap);
        send_bits(d, DW, maxgap);
        gap(maxgap, 1'b1);
        bus.bit_valid = 1'b1;
        bus.bit_in    = p;
        push_exp(d, p);
        tick();
        chk("busy_after_par", 32'(bus.busy), 0);
        chk("sb_drained", sb.size(), 0);
        bus.bit_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n         = 1'b1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.abort     = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(bus.data_out), 0);
        chk("rst_data_valid", 32'(bus.data_valid), 0);
        chk("rst_par_err", 32'(bus.par_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_err_count", 32'(bus.err_count), 0);
        rst_n = 1'b1;
        tick();

        // Good frame, then confirm the strobe is one cycle wide.
        send_frame(8'hA5, 1'b1, 0);
        tick();
        chk("strobe_one_cycle", 32'(bus.data_valid), 0);

        // Bad frame then good frame: counter increments once, then holds.
        send_frame(8'hA5, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 0);
        tick();

        // Gapped frame.
        send_frame(8'h3C, 1'b1, 3);
        tick();

        // abort in IDLE changes nothing.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_data", 32'(bus.data_out), 32'h3C);
        chk("idle_abort_busy", 32'(bus.busy), 0);

        // Abort after 5 bits; held outputs survive, no strobe.
        send_bits(8'hFF, 5, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_hold_data", 32'(bus.data_out), 32'h3C);
        chk("abort_hold_perr", 32'(bus.par_err), 0);
        chk("abort_hold_cnt", 32'(bus.err_count), 1);
        send_frame(8'h00, 1'b1, 0);

        // abort coincident with a valid bit drops that bit.
        send_bits(8'hFF, 3, 0);
        bus.abort     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.bit_valid = 1'b0;
        chk("abort_valid_busy", 32'(bus.busy), 0);
        send_frame(8'h5A, 1'b1, 0);

        // Asynchronous reset mid-frame.
        send_bits(8'hFF, 4, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_data_out", 32'(bus.data_out), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        chk("mid_rst_err_count", 32'(bus.err_count), 0);
        chk("mid_rst_par_err", 32'(bus.par_err), 0);
        model_cnt = 0;
        tick();
        rst_n = 1'b1;
        send_frame(8'h81, 1'b1, 0);

        // Back-to-back bad frames to saturate the counter.
        b2b         = 1'b1;
        last_strobe = -1;
        for (int k = 0; k < 261; k++) begin
            d = DW'($urandom());
            send_frame(d, ^d, 0);
        end
        b2b = 1'b0;
        tick();
        chk("sat_err_count", 32'(bus.err_count), 255);
        chk("sat_strobe_low", 32'(bus.data_valid), 0);
        chk("strobe_total", n_strobe, n_push);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
